uart_line_monitor: RTL



---
 rtl/uart_line_monitor_pkg.sv | 23 ++
 rtl/uart_line_monitor_if.sv | 12 +
 rtl/uart_line_monitor_baud_gen.sv | 33 +++
 rtl/uart_line_monitor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_line_monitor_pkg.sv
// Shared types and constants for the UART line monitor.
// The PARITY state exists only when UART_LINE_MONITOR_PARITY_EN is defined.
package uart_line_monitor_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 8;

   // Sample-counter values at which the start midpoint and each later bit midpoint fall
   localparam logic [3:0] TICK_MID  = 4'(MID_SAMPLE - 1);
   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
`ifdef UART_LINE_MONITOR_PARITY_EN
      PARITY    = 3'd3,
`endif
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } state_e;

endpackage

// File: rtl/uart_line_monitor_if.sv
// Received-frame bus: last byte plus the per-frame valid and error pulses.
interface uart_line_monitor_if;

   logic [7:0] DATA_OUT;
   logic       DATA_VALID;
   logic       PARITY_ERR;
   logic       FRAMING_ERR;

   modport master (output DATA_OUT, DATA_VALID, PARITY_ERR, FRAMING_ERR);
   modport slave  (input  DATA_OUT, DATA_VALID, PARITY_ERR, FRAMING_ERR);

endinterface

// File: rtl/uart_line_monitor_baud_gen.sv
// 16x oversampling tick divider: one tick every baud_value_i+1 clocks.
// A new divisor is picked up only when the counter wraps.
module uart_line_monitor_baud_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic [12:0] baud_value_i,
   output logic        tick_o
);

   logic [12:0] cnt_q, cnt_d;
   logic [12:0] limit_q, limit_d;

   always_comb begin
      tick_o  = (cnt_q == limit_q);
      cnt_d   = cnt_q + 13'd1;
      limit_d = limit_q;
      if (tick_o) begin
         cnt_d   = '0;
         limit_d = baud_value_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         limit_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         limit_q <= limit_d;
      end
   end

endmodule

// File: rtl/uart_line_monitor.sv
// Passive UART receiver/monitor with saturating frame and error counters.
// Parity checking is compiled in only when UART_LINE_MONITOR_PARITY_EN is defined.
module uart_line_monitor
   import uart_line_monitor_pkg::*;
#(
   parameter int CNT_WIDTH   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 PCLK,
   input  logic                 PRESET,
   input  logic                 RX,
   input  logic [12:0]          BAUD_VALUE,
   input  logic                 BIT8,
   input  logic                 PARITY_EN,
   input  logic                 ODD_N_EVEN,
   input  logic                 CLR_CNT,
   uart_line_monitor_if.master  mon,
   output logic                 RX_BUSY,
   output logic [CNT_WIDTH-1:0] FRAME_CNT,
   output logic [CNT_WIDTH-1:0] ERR_CNT
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic tick;

   uart_line_monitor_baud_gen u_baud (
      .clk          (PCLK),
      .rst          (PRESET),
      .baud_value_i (BAUD_VALUE),
      .tick_o       (tick)
   );

   // Synchronizer resets to the idle level so release never looks like a start edge
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   logic                   rx_prev_q;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         sync_q    <= '1;
         rx_prev_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], RX};
         rx_prev_q <= rx_s;
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

   state_e     state_q, state_d;
   logic [3:0] tick_cnt_q, tick_cnt_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       cfg_bit8_q, cfg_bit8_d;
   logic [7:0] data_out_q, data_out_d;
   logic       valid_q, valid_d;
   logic       ferr_q, ferr_d;
   logic       bit_done;
   logic       frame_err;
`ifdef UART_LINE_MONITOR_PARITY_EN
   logic       cfg_par_q, cfg_par_d;
   logic       cfg_odd_q, cfg_odd_d;
   logic       par_err_q, par_err_d;
   logic       perr_q, perr_d;
`else
   logic       unused_cfg;
   assign unused_cfg = PARITY_EN ^ ODD_N_EVEN;
`endif

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      cfg_bit8_d = cfg_bit8_q;
      data_out_d = data_out_q;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;
`ifdef UART_LINE_MONITOR_PARITY_EN
      cfg_par_d  = cfg_par_q;
      cfg_odd_d  = cfg_odd_q;
      par_err_d  = par_err_q;
      perr_d     = 1'b0;
`endif
      bit_done   = tick && (tick_cnt_q == TICK_LAST);
      if (tick) tick_cnt_d = tick_cnt_q + 4'd1;

      case (state_q)
         IDLE: begin
            tick_cnt_d = '0;
            if (rx_prev_q && !rx_s) begin
               state_d    = START;
               bit_cnt_d  = '0;
               shift_d    = '0;
               cfg_bit8_d = BIT8;
`ifdef UART_LINE_MONITOR_PARITY_EN
               cfg_par_d  = PARITY_EN;
               cfg_odd_d  = ODD_N_EVEN;
               par_err_d  = 1'b0;
`endif
            end
         end
         START: begin
            if (tick && (tick_cnt_q == TICK_MID)) begin
               tick_cnt_d = '0;
               state_d    = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               shift_d[bit_cnt_q] = rx_s;
               bit_cnt_d          = bit_cnt_q + 3'd1;
               if (bit_cnt_q == (cfg_bit8_q ? 3'd7 : 3'd6)) begin
`ifdef UART_LINE_MONITOR_PARITY_EN
                  state_d = cfg_par_q ? PARITY : STOP;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_LINE_MONITOR_PARITY_EN
         PARITY: begin
            if (bit_done) begin
               par_err_d = ((^shift_q) ^ rx_s) != cfg_odd_q;
               state_d   = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_done) begin
               data_out_d = shift_q;
               valid_d    = 1'b1;
               ferr_d     = !rx_s;
`ifdef UART_LINE_MONITOR_PARITY_EN
               perr_d     = par_err_q;
`endif
               // A low stop bit may be the start of a break; wait it out
               state_d    = rx_s ? IDLE : WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         cfg_bit8_q <= 1'b1;
         data_out_q <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
`ifdef UART_LINE_MONITOR_PARITY_EN
         cfg_par_q  <= 1'b0;
         cfg_odd_q  <= 1'b0;
         par_err_q  <= 1'b0;
         perr_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         cfg_bit8_q <= cfg_bit8_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
`ifdef UART_LINE_MONITOR_PARITY_EN
         cfg_par_q  <= cfg_par_d;
         cfg_odd_q  <= cfg_odd_d;
         par_err_q  <= par_err_d;
         perr_q     <= perr_d;
`endif
      end
   end

`ifdef UART_LINE_MONITOR_PARITY_EN
   assign frame_err      = perr_q | ferr_q;
   assign mon.PARITY_ERR = perr_q;
`else
   assign frame_err      = ferr_q;
   assign mon.PARITY_ERR = 1'b0;
`endif
   assign mon.DATA_OUT    = data_out_q;
   assign mon.DATA_VALID  = valid_q;
   assign mon.FRAMING_ERR = ferr_q;
   assign RX_BUSY         = (state_q != IDLE);

   // Counters advance the cycle after the frame pulse; a clear in that cycle wins
   logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      if (CLR_CNT) begin
         frame_cnt_d = '0;
         err_cnt_d   = '0;
      end else if (valid_q) begin
         if (frame_cnt_q != CNT_MAX) frame_cnt_d = frame_cnt_q + CNT_ONE;
         if (frame_err && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign FRAME_CNT = frame_cnt_q;
   assign ERR_CNT   = err_cnt_q;

endmodule
